// File: rtl/box_controller_multi_if.sv
// Control/coordinate bundle between the button front-end and box_controller_multi.
// The master side drives the operator controls; the slave side returns box coordinates and status.
interface box_controller_multi_if #(
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned SW        = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
);
  logic                    mode_sel;
  logic                    resize_mode_sel;
  logic                    speed_sel;
  logic [SW-1:0]           box_sel;
  logic [3:0]              butns;
  logic [NUM_BOXES*16-1:0] x1_o;
  logic [NUM_BOXES*16-1:0] x2_o;
  logic [NUM_BOXES*16-1:0] y1_o;
  logic [NUM_BOXES*16-1:0] y2_o;
  logic [SW-1:0]           active_box_o;
  logic                    busy_o;
  logic [2:0]              leds;

  modport master (
    output mode_sel, resize_mode_sel, speed_sel, box_sel, butns,
    input  x1_o, x2_o, y1_o, y2_o, active_box_o, busy_o, leds
  );

  modport slave (
    input  mode_sel, resize_mode_sel, speed_sel, box_sel, butns,
    output x1_o, x2_o, y1_o, y2_o, active_box_o, busy_o, leds
  );
endinterface

// File: rtl/box_controller_multi.sv
// Button-driven move/resize controller for NUM_BOXES overlay boxes.
// Press -> APPLY -> HOLD with auto-repeat; coordinates saturate at the image edges.
// Optional macro BOX_CTRL_ACCEL_EN: after 8 consecutive auto-repeats the step becomes 4*STEP.
module box_controller_multi #(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 720,
  parameter int unsigned NUM_BOXES    = 4,
  parameter int unsigned STEP         = 10,
  parameter int unsigned MIN_BOX      = 16,
  parameter int unsigned MAX_BOX      = 300,
  parameter int unsigned INIT_BOX     = 50,
  parameter int unsigned FAST_DELAY   = 1000000,
  parameter int unsigned SLOW_DELAY   = 5000000,
  parameter int unsigned HOLD_DELAY   = 30000000
) (
  input logic                   clk,
  input logic                   rst,
  box_controller_multi_if.slave bus
);

  localparam int unsigned SW  = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam int unsigned CW  = 32;
  localparam int unsigned CRW = 12;
  localparam int unsigned AW  = CRW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [1:0] M_MOVE = 2'd0;
  localparam logic [1:0] M_UNI  = 2'd1;
  localparam logic [1:0] M_IND  = 2'd2;

  localparam logic signed [AW-1:0] C_ZERO = AW'(0);
  localparam logic signed [AW-1:0] C_ONE  = AW'(1);
  localparam logic signed [AW-1:0] C_STEP = AW'(STEP);
  localparam logic signed [AW-1:0] C_MIN  = AW'(MIN_BOX);
  localparam logic signed [AW-1:0] C_MAX  = AW'(MAX_BOX);
  localparam logic signed [AW-1:0] C_XLIM = AW'(IMAGE_WIDTH - 1);
  localparam logic signed [AW-1:0] C_YLIM = AW'(IMAGE_HEIGHT - 1);

  function automatic logic signed [AW-1:0] f_min(input logic signed [AW-1:0] a,
                                                 input logic signed [AW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // One axis of an action: returns {new_lo, new_hi}; opposing buttons cancel.
  function automatic logic [2*AW-1:0] f_axis(input logic signed [AW-1:0] lo,
                                             input logic signed [AW-1:0] hi,
                                             input logic neg, input logic pos,
                                             input logic [1:0] md,
                                             input logic signed [AW-1:0] s,
                                             input logic signed [AW-1:0] lim);
    logic signed [AW-1:0] sz, dn, dp, room, nlo, nhi;
    sz   = hi - lo + C_ONE;
    dn   = f_min(s, lo);
    dp   = f_min(s, lim - hi);
    room = C_MAX - sz;
    if (room < C_ZERO) room = C_ZERO;
    nlo  = lo;
    nhi  = hi;
    if (neg != pos) begin
      case (md)
        M_MOVE: begin
          if (neg) begin nlo = lo - dn; nhi = hi - dn; end
          else     begin nlo = lo + dp; nhi = hi + dp; end
        end
        M_UNI: begin
          if (neg) begin
            if (sz + (s <<< 1) <= C_MAX) begin nlo = lo - dn; nhi = hi + dp; end
          end else if (sz - (s <<< 1) >= C_MIN) begin
            nlo = lo + s;
            nhi = hi - s;
          end
        end
        M_IND: begin
          if (neg) nlo = lo - f_min(dn, room);
          else     nhi = hi + f_min(dp, room);
        end
        default: ;
      endcase
    end
    return {nlo, nhi};
  endfunction

  logic [1:0]           r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_first, w_first_nxt;
  logic [3:0]           r_butns, r_butns_d;
  logic [SW-1:0]        r_active;
  logic [2:0]           r_leds;
  logic                 r_busy;
  logic [CRW-1:0]       r_x1 [NUM_BOXES];
  logic [CRW-1:0]       r_x2 [NUM_BOXES];
  logic [CRW-1:0]       r_y1 [NUM_BOXES];
  logic [CRW-1:0]       r_y2 [NUM_BOXES];

  logic                 w_press;
  logic [1:0]           w_mode;
  logic [SW-1:0]        w_sel;
  logic signed [AW-1:0] w_step;
  logic signed [AW-1:0] w_cx1, w_cx2, w_cy1, w_cy2;
  logic signed [AW-1:0] w_nx1, w_nx2, w_ny1, w_ny2;
  logic                 w_xneg, w_xpos;

`ifdef BOX_CTRL_ACCEL_EN
  localparam logic signed [AW-1:0] C_STEP4 = AW'(4 * STEP);
  logic [3:0] r_rep, w_rep_nxt;
  assign w_step = (!r_first && r_rep == 4'd8) ? C_STEP4 : C_STEP;
`else
  assign w_step = C_STEP;
`endif

  assign w_press = |(r_butns & ~r_butns_d);
  assign w_mode  = !bus.mode_sel ? M_MOVE : (bus.resize_mode_sel ? M_IND : M_UNI);
  assign w_sel   = (32'(bus.box_sel) < NUM_BOXES) ? bus.box_sel : r_active;
  assign w_cx1   = $signed({1'b0, r_x1[w_sel]});
  assign w_cx2   = $signed({1'b0, r_x2[w_sel]});
  assign w_cy1   = $signed({1'b0, r_y1[w_sel]});
  assign w_cy2   = $signed({1'b0, r_y2[w_sel]});
  assign w_xneg  = (w_mode == M_UNI) ? r_butns[2] : r_butns[0];
  assign w_xpos  = (w_mode == M_UNI) ? r_butns[3] : r_butns[1];
  assign {w_nx1, w_nx2} = f_axis(w_cx1, w_cx2, w_xneg, w_xpos, w_mode, w_step, C_XLIM);
  assign {w_ny1, w_ny2} = f_axis(w_cy1, w_cy2, r_butns[2], r_butns[3], w_mode, w_step, C_YLIM);

  // FSM state, repeat counter and first-apply flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b1;
`ifdef BOX_CTRL_ACCEL_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
`ifdef BOX_CTRL_ACCEL_EN
      r_rep   <= w_rep_nxt;
`endif
    end
  end

  // Next-state logic: press starts, counter expiry repeats, release returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
`ifdef BOX_CTRL_ACCEL_EN
    w_rep_nxt   = r_rep;
`endif
    case (r_state)
      S_IDLE: begin
        w_first_nxt = 1'b1;
`ifdef BOX_CTRL_ACCEL_EN
        w_rep_nxt   = '0;
`endif
        if (w_press) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_first_nxt = 1'b0;
        w_cnt_nxt   = r_first ? CW'(HOLD_DELAY)
                              : (bus.speed_sel ? CW'(SLOW_DELAY) : CW'(FAST_DELAY));
`ifdef BOX_CTRL_ACCEL_EN
        if (!r_first && r_rep != 4'd8) w_rep_nxt = r_rep + 4'd1;
`endif
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_butns == 4'd0)  w_state_nxt = S_IDLE;
        else if (r_cnt == '0) w_state_nxt = S_APPLY;
        else                  w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Button sampling, status outputs and per-box coordinate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_butns   <= '0;
      r_butns_d <= '0;
      r_active  <= '0;
      r_leds    <= 3'b001;
      r_busy    <= 1'b0;
      for (int i = 0; i < int'(NUM_BOXES); i++) begin
        r_x1[i] <= CRW'(i * INIT_BOX);
        r_x2[i] <= CRW'(i * INIT_BOX + INIT_BOX - 1);
        r_y1[i] <= '0;
        r_y2[i] <= CRW'(INIT_BOX - 1);
      end
    end else begin
      r_butns   <= bus.butns;
      r_butns_d <= r_butns;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_leds    <= (w_mode == M_MOVE) ? 3'b001 : ((w_mode == M_UNI) ? 3'b010 : 3'b100);
      if (r_state != S_HOLD) r_active <= w_sel;
      for (int i = 0; i < int'(NUM_BOXES); i++) begin
        if (r_state == S_APPLY && w_sel == SW'(i)) begin
          r_x1[i] <= w_nx1[CRW-1:0];
          r_x2[i] <= w_nx2[CRW-1:0];
          r_y1[i] <= w_ny1[CRW-1:0];
          r_y2[i] <= w_ny2[CRW-1:0];
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_BOXES); g++) begin : g_out
    assign bus.x1_o[16*g +: 16] = {4'd0, r_x1[g]};
    assign bus.x2_o[16*g +: 16] = {4'd0, r_x2[g]};
    assign bus.y1_o[16*g +: 16] = {4'd0, r_y1[g]};
    assign bus.y2_o[16*g +: 16] = {4'd0, r_y2[g]};
  end

  assign bus.active_box_o = r_active;
  assign bus.busy_o       = r_busy;
  assign bus.leds         = r_leds;

endmodule

// File: tb/tb_box_controller_multi.sv
// Scoreboard bench for box_controller_multi: stimulus pushes the predicted box state,
// a monitor pops and compares each time the controller drops busy_o.
module tb_box_controller_multi;
  localparam int NB    = 4;
  localparam int W     = 1284;
  localparam int H     = 720;
  localparam int STEP  = 10;
  localparam int MINB  = 16;
  localparam int MAXB  = 300;
  localparam int INITB = 50;
  localparam int FD    = 10;
  localparam int SD    = 15;
  localparam int HD    = 20;

  typedef struct packed {
    logic [NB*16-1:0] x1;
    logic [NB*16-1:0] x2;
    logic [NB*16-1:0] y1;
    logic [NB*16-1:0] y2;
    logic [1:0]       act;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   mx1[NB], mx2[NB], my1[NB], my2[NB];
  exp_t q[$];

  always #5 clk = ~clk;

  box_controller_multi_if #(.NUM_BOXES(NB)) bus();

  box_controller_multi #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_BOXES(NB), .STEP(STEP),
    .MIN_BOX(MINB), .MAX_BOX(MAXB), .INIT_BOX(INITB),
    .FAST_DELAY(FD), .SLOW_DELAY(SD), .HOLD_DELAY(HD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mx1[i] = i * INITB; mx2[i] = i * INITB + INITB - 1;
      my1[i] = 0;         my2[i] = INITB - 1;
    end
  endfunction

  // Reference rule for one axis; md 0=move 1=uniform 2=independent
  function automatic void axis(inout int lo, inout int hi, input bit neg, input bit pos,
                               input int md, input int s, input int lim);
    int sz, nl, nh;
    sz = hi - lo + 1;
    if (neg == pos) return;
    case (md)
      0: if (neg) begin nl = imax(lo - s, 0); hi = hi - (lo - nl); lo = nl; end
         else     begin nh = imin(hi + s, lim); lo = lo + (nh - hi); hi = nh; end
      1: if (neg) begin
           if (sz + 2 * s <= MAXB) begin lo = imax(lo - s, 0); hi = imin(hi + s, lim); end
         end else if (sz - 2 * s >= MINB) begin lo = lo + s; hi = hi - s; end
      default: if (neg) lo = imax(imax(lo - s, 0), hi - MAXB + 1);
               else     hi = imin(imin(hi + s, lim), lo + MAXB - 1);
    endcase
  endfunction

  function automatic void model_apply(int bx, int md, logic [3:0] b, int s);
    int x1, x2, y1, y2;
    x1 = mx1[bx]; x2 = mx2[bx]; y1 = my1[bx]; y2 = my2[bx];
    axis(x1, x2, (md == 1) ? b[2] : b[0], (md == 1) ? b[3] : b[1], md, s, W - 1);
    axis(y1, y2, b[2], b[3], md, s, H - 1);
    mx1[bx] = x1; mx2[bx] = x2; my1[bx] = y1; my2[bx] = y2;
  endfunction

  function automatic int step_of(int k);
`ifdef BOX_CTRL_ACCEL_EN
    return (k >= 9) ? 4 * STEP : STEP;
`else
    return STEP;
`endif
  endfunction

  // Clock offset of the k-th APPLY relative to the first one
  function automatic int ofs(int k, int d);
    return (k == 0) ? 0 : (HD + 2) + (k - 1) * (d + 2);
  endfunction

  function automatic exp_t snap(int act);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.x1[16*i +: 16] = 16'(mx1[i]); e.x2[16*i +: 16] = 16'(mx2[i]);
      e.y1[16*i +: 16] = 16'(my1[i]); e.y2[16*i +: 16] = 16'(my2[i]);
    end
    e.act = 2'(act);
    return e;
  endfunction

  function automatic int dx1(int i); return int'(bus.x1_o[16*i +: 16]); endfunction
  function automatic int dx2(int i); return int'(bus.x2_o[16*i +: 16]); endfunction
  function automatic int dy1(int i); return int'(bus.y1_o[16*i +: 16]); endfunction
  function automatic int dy2(int i); return int'(bus.y2_o[16*i +: 16]); endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy_o !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy_o !== 1'b0) begin
      checks++; errs++;
      $display("FAIL busy_timeout: busy_o still %b after %0d cycles", bus.busy_o, t);
    end
  endtask

  task automatic configure(int md, int sp, int bx);
    @(negedge clk);
    bus.mode_sel        = (md != 0);
    bus.resize_mode_sel = (md == 2);
    bus.speed_sel       = sp[0];
    bus.box_sel         = 2'(bx);
    bus.butns           = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("leds", int'(bus.leds), (md == 0) ? 1 : ((md == 1) ? 2 : 4));
  endtask

  // Hold buttons b long enough for exactly n APPLYs, releasing mid-interval
  task automatic txn(int md, int sp, int bx, logic [3:0] b, int n);
    int d, len;
    configure(md, sp, bx);
    d = sp ? SD : FD;
    for (int k = 0; k < n; k++) model_apply(bx, md, b, step_of(k));
    q.push_back(snap(bx));
    len = ofs(n - 1, d) + 1 + (ofs(n, d) - ofs(n - 1, d)) / 2;
    bus.butns = b;
    repeat (len) @(negedge clk);
    bus.butns = 4'd0;
    wait_idle();
  endtask

  // Monitor: every busy_o fall marks a finished transaction
  initial begin
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (pb === 1'b1 && bus.busy_o === 1'b0) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL sb_unexpected: busy_o fell with no pending expectation");
        end else begin
          e = q.pop_front();
          for (int i = 0; i < NB; i++) begin
            check($sformatf("sb_box%0d_x1", i), dx1(i), int'(e.x1[16*i +: 16]));
            check($sformatf("sb_box%0d_x2", i), dx2(i), int'(e.x2[16*i +: 16]));
            check($sformatf("sb_box%0d_y1", i), dy1(i), int'(e.y1[16*i +: 16]));
            check($sformatf("sb_box%0d_y2", i), dy2(i), int'(e.y2[16*i +: 16]));
          end
          check("sb_active", int'(bus.active_box_o), int'(e.act));
        end
      end
      pb = bus.busy_o;
    end
  end

  initial begin
    int n;
    bus.mode_sel = 1'b0; bus.resize_mode_sel = 1'b0; bus.speed_sel = 1'b0;
    bus.box_sel = 2'd0;  bus.butns = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_box2_x1", dx1(2), 100); check("rst_box2_y1", dy1(2), 0);
    check("rst_box2_x2", dx2(2), 149); check("rst_box2_y2", dy2(2), 49);
    check("rst_leds", int'(bus.leds), 1);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_active", int'(bus.active_box_o), 0);

    // Latency: right on box 1, 5-clock pulse
    configure(0, 0, 1);
    model_apply(1, 0, 4'b0010, STEP);
    q.push_back(snap(1));
    bus.butns = 4'b0010;
    @(posedge clk);
    @(posedge clk); #1;
    check("lat_e1_x1", dx1(1), 50);
    @(posedge clk); #1;
    check("lat_e2_x1", dx1(1), 60);
    check("lat_e2_x2", dx2(1), 109);
    repeat (3) @(negedge clk);
    bus.butns = 4'd0;
    wait_idle();
    check("lat_idle_busy", int'(bus.busy_o), 0);

    // Uniform shrink stops at MIN_BOX
    txn(0, 0, 2, 4'b1000, 5);
    txn(0, 1, 2, 4'b1000, 5);
    check("uni_pre_y1", dy1(2), 100);
    txn(1, 0, 2, 4'b1000, 3);
    check("uni_x1", dx1(2), 110); check("uni_x2", dx2(2), 139);
    check("uni_y1", dy1(2), 110); check("uni_y2", dy2(2), 139);

    // Opposing x buttons cancel, y still moves
    txn(0, 0, 3, 4'b1011, 3);
    check("cancel_x1", dx1(3), 150); check("cancel_y1", dy1(3), 30);
    check("cancel_y2", dy2(3), 79);

    // Reset while in HOLD
    @(negedge clk);
    bus.butns = 4'b1011;
    model_reset();
    q.push_back(snap(0));
    repeat (8) @(negedge clk);
    rst = 1'b1;
    bus.butns = 4'd0;
    @(posedge clk); #1;
    check("midrst_box3_x1", dx1(3), 150); check("midrst_box3_y1", dy1(3), 0);
    check("midrst_box3_y2", dy2(3), 49);  check("midrst_busy", int'(bus.busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Repeat 9 uses 4*STEP only with acceleration
    txn(0, 0, 0, 4'b0010, 10);
`ifdef BOX_CTRL_ACCEL_EN
    check("accel_x1", dx1(0), 130);
`else
    check("accel_x1", dx1(0), 100);
`endif

    // Drive box 0 to the right edge, then back to x1=4 and saturate left
    while (mx2[0] < W - 1) txn(0, 0, 0, 4'b0010, 8);
    check("edge_x2", dx2(0), W - 1);
    while (mx1[0] > 4) begin
      n = imin(8, (mx1[0] - 4) / 10);
      if (n == 0) n = 1;
      txn(0, 0, 0, 4'b0001, n);
    end
    check("sat_pre_x1", dx1(0), 4);
    txn(0, 0, 0, 4'b0001, 1);
    check("sat_x1", dx1(0), 0); check("sat_x2", dx2(0), 49);
    txn(0, 0, 0, 4'b0001, 1);
    check("sat2_x1", dx1(0), 0); check("sat2_x2", dx2(0), 49);

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)),
          4'($urandom_range(1, 15)), int'($urandom_range(1, 10)));
    end

    repeat (4) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
